fcp6_responder: RTL and testbench

//  FCP6 slave-side endpoint. Deserialises the master's 2-bit data/ctrl link and decodes the header.

---
 rtl/fcp6_pkg.sv | 39 +++
 rtl/fcp6_responder_if.sv | 25 ++
 rtl/fcp6_sym_deser.sv | 33 +++
 rtl/fcp6_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_fcp6_responder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fcp6_pkg.sv
// Shared FCP6 link constants: ctrl/cmd codes, header field positions, responder FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fcp6_pkg;

    localparam logic [1:0] CTRL_IDLE   = 2'b00;
    localparam logic [1:0] CTRL_HEADER = 2'b01;
    localparam logic [1:0] CTRL_DATA   = 2'b10;
    localparam logic [1:0] CTRL_END    = 2'b11;

    localparam logic [1:0] CMD_WR    = 2'b01;
    localparam logic [1:0] CMD_RD    = 2'b10;
    localparam logic [1:0] SYNC_MARK = 2'b11;

    // Header byte: [7:6] cmd, [5:2] addr, [1:0] sync marker
    localparam int HDR_CMD_MSB  = 7;
    localparam int HDR_CMD_LSB  = 6;
    localparam int HDR_ADDR_MSB = 5;
    localparam int HDR_ADDR_LSB = 2;
    localparam int HDR_SYNC_MSB = 1;
    localparam int HDR_SYNC_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WEND,
        ST_RDRV,
        ST_RESP,
        ST_ERR
    } state_t;

    // True when the header carries the given command and a correct sync marker.
    function automatic logic hdr_is(input logic [7:0] hdr, input logic [1:0] cmd);
        return (hdr[HDR_CMD_MSB:HDR_CMD_LSB] == cmd) &&
               (hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] == SYNC_MARK);
    endfunction

endpackage

// File: rtl/fcp6_responder_if.sv
// FCP6 link bundle: master->responder ctrl/data symbols, responder->master response and status.
// Latency: n/a (wiring only).
// Backpressure: none on the link; the master paces itself on busy.
interface fcp6_responder_if;
    logic [1:0] bus_ctrl;
    logic [1:0] bus_data;
    logic [1:0] rsp_data;
    logic       rsp_valid;
    logic       ack;
    logic       nak;
    logic       busy;
    logic [3:0] rx_addr;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output bus_ctrl, bus_data,
        input  rsp_data, rsp_valid, ack, nak, busy, rx_addr, rx_data, rx_valid
    );

    modport slave (
        input  bus_ctrl, bus_data,
        output rsp_data, rsp_valid, ack, nak, busy, rx_addr, rx_data, rx_valid
    );
endinterface

// File: rtl/fcp6_sym_deser.sv
// 2-bit symbol to byte shifter, MSB pair first, with symbol counter and byte-complete strobe.
// Latency: byte readable on o_byte the cycle after its 4th symbol; o_byte_done is combinational.
// Backpressure: none; a symbol is taken on every cycle i_sym_vld is high.
module fcp6_sym_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sym_vld,
    input  logic       i_clr,
    input  logic [1:0] i_sym,
    output logic [1:0] o_cnt,
    output logic [7:0] o_byte,
    output logic       o_byte_done
);
    logic [1:0] r_cnt;
    logic [7:0] r_byte;

    // Shift accepted symbols in; the count restarts whenever the owner stops feeding symbols.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_byte <= 8'h00;
        end else if (i_sym_vld) begin
            r_cnt  <= r_cnt + 2'd1;
            r_byte <= {r_byte[5:0], i_sym};
        end else if (i_clr) begin
            r_cnt  <= 2'd0;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_byte      = r_byte;
    assign o_byte_done = i_sym_vld && (r_cnt == 2'd3);
endmodule

// File: rtl/fcp6_responder.sv
// FCP6 responder: decodes header/data frames, writes or reads a 16x8 regfile, answers on rsp lane.
// Latency: write ack 1 cycle after END; read data 1..4 cycles after END, ack 5 after END (+1 with FCP6_PARITY_EN).
// Backpressure: none; busy tells the master when a new frame may start. FCP6_PARITY_EN adds a parity symbol.
module fcp6_responder
    import fcp6_pkg::*;
#(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    fcp6_responder_if.slave  bus
);
`ifdef FCP6_PARITY_EN
    localparam int RSP_SYMS = 5;
`else
    localparam int RSP_SYMS = 4;
`endif

    state_t                   r_state, w_state_nxt;
    logic [1:0]               w_cnt;
    logic [DATA_W-1:0]        w_byte;
    logic                     w_byte_done;
    logic                     w_accept, w_clr;
    logic [7:0]               r_hdr;
    logic [DATA_W-1:0]        r_rf [2**ADDR_W];
    logic [2*RSP_SYMS-1:0]    r_rsp, w_rsp_load;
    logic [2:0]               r_rcnt;
    logic                     r_ack, r_nak, r_rx_valid;
    logic [ADDR_W-1:0]        r_rx_addr;
    logic [DATA_W-1:0]        r_rx_data;
    logic                     w_ack_nxt, w_nak_nxt, w_wr_en, w_rd_load;
    logic                     w_rd_ok, w_wr_ok, w_par_ok, w_rsp_vld;
    logic [ADDR_W-1:0]        w_addr;
    logic [DATA_W-1:0]        w_rd_byte;

    assign w_clr = !w_accept;

    fcp6_sym_deser u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sym_vld   (w_accept),
        .i_clr       (w_clr),
        .i_sym       (bus.bus_data),
        .o_cnt       (w_cnt),
        .o_byte      (w_byte),
        .o_byte_done (w_byte_done)
    );

    assign w_addr    = r_hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign w_rd_ok   = hdr_is(r_hdr, CMD_RD);
    assign w_wr_ok   = hdr_is(r_hdr, CMD_WR);
    assign w_rd_byte = r_rf[w_addr];

`ifdef FCP6_PARITY_EN
    logic r_par, r_par_vld, w_par_cap;

    // Hold the parity symbol of the current write; forgotten as soon as the data phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par     <= 1'b0;
            r_par_vld <= 1'b0;
        end else if (r_state != ST_DATA) begin
            r_par_vld <= 1'b0;
        end else if (w_par_cap) begin
            r_par     <= bus.bus_data[0];
            r_par_vld <= 1'b1;
        end
    end

    assign w_par_ok   = r_par_vld && (r_par == ^w_byte);
    assign w_rsp_load = {w_rd_byte, 1'b0, ^w_rd_byte};
`else
    assign w_par_ok   = 1'b1;
    assign w_rsp_load = w_rd_byte;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, symbol acceptance and the pulses registered for the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_nak_nxt   = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_load   = 1'b0;
`ifdef FCP6_PARITY_EN
        w_par_cap   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.bus_ctrl == CTRL_HEADER) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_HDR;
                end else if (bus.bus_ctrl != CTRL_IDLE) begin
                    w_nak_nxt   = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_HDR: begin
                if (w_cnt != 2'd0) begin
                    if (bus.bus_ctrl == CTRL_HEADER) begin
                        w_accept = 1'b1;
                    end else begin
                        w_nak_nxt   = 1'b1;
                        w_state_nxt = ST_ERR;
                    end
                end else if (bus.bus_ctrl == CTRL_DATA && !w_rd_ok) begin
                    // Bad headers still consume their data; the verdict comes at END.
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DATA;
                end else if (bus.bus_ctrl == CTRL_END) begin
                    if (w_rd_ok) begin
                        w_rd_load   = 1'b1;
                        w_state_nxt = ST_RDRV;
                    end else begin
                        w_nak_nxt   = 1'b1;
                        w_state_nxt = ST_WEND;
                    end
                end else begin
                    w_nak_nxt   = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DATA: begin
                if (w_cnt != 2'd0) begin
                    if (bus.bus_ctrl == CTRL_DATA) begin
                        w_accept = 1'b1;
                    end else begin
                        w_nak_nxt   = 1'b1;
                        w_state_nxt = ST_ERR;
                    end
                end else if (bus.bus_ctrl == CTRL_END) begin
                    if (w_wr_ok && w_par_ok) begin
                        w_ack_nxt = 1'b1;
                        w_wr_en   = 1'b1;
                    end else begin
                        w_nak_nxt = 1'b1;
                    end
                    w_state_nxt = ST_WEND;
                end
`ifdef FCP6_PARITY_EN
                else if (bus.bus_ctrl == CTRL_DATA && !r_par_vld) begin
                    w_par_cap = 1'b1;
                end
`endif
                else begin
                    w_nak_nxt   = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_WEND: w_state_nxt = ST_IDLE;
            ST_RDRV: begin
                if (r_rcnt == 3'(RSP_SYMS - 1)) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            ST_ERR: begin
                if (bus.bus_ctrl == CTRL_IDLE) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the header as its last symbol arrives so the deserialiser is free for data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_hdr <= 8'h00;
        else if (r_state == ST_HDR && w_byte_done) r_hdr <= {w_byte[5:0], bus.bus_data};
    end

    // Register file: written only on an accepted write at END.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_rf[i] <= RESET_VAL;
        end else if (w_wr_en) begin
            r_rf[w_addr] <= w_byte;
        end
    end

    // Completion pulses and the last-write record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= 1'b0;
            r_nak      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_addr  <= '0;
            r_rx_data  <= '0;
        end else begin
            r_ack      <= w_ack_nxt;
            r_nak      <= w_nak_nxt;
            r_rx_valid <= w_wr_en;
            if (w_wr_en) begin
                r_rx_addr <= w_addr;
                r_rx_data <= w_byte;
            end
        end
    end

    // Read response shifter: snapshot at END, then one symbol per cycle MSB pair first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp  <= '0;
            r_rcnt <= 3'd0;
        end else if (w_rd_load) begin
            r_rsp  <= w_rsp_load;
            r_rcnt <= 3'd0;
        end else if (r_state == ST_RDRV) begin
            r_rsp  <= r_rsp << 2;
            r_rcnt <= r_rcnt + 3'd1;
        end
    end

    assign w_rsp_vld     = (r_state == ST_RDRV);
    assign bus.rsp_valid = w_rsp_vld;
    assign bus.rsp_data  = w_rsp_vld ? r_rsp[2*RSP_SYMS-1 -: 2] : 2'b00;
    assign bus.ack       = r_ack;
    assign bus.nak       = r_nak;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.rx_addr   = r_rx_addr;
    assign bus.rx_data   = r_rx_data;
    // busy rises combinationally with the first header symbol, and is forced low in reset.
    assign bus.busy      = rst_n && ((r_state != ST_IDLE) || (bus.bus_ctrl == CTRL_HEADER));
endmodule

// File: tb/tb_fcp6_responder.sv
// Bench for fcp6_responder: directed frames then random frames against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fcp6_responder;
    import fcp6_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fcp6_responder_if bus ();

    fcp6_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Frame-level model state
    logic [7:0] m_rf [16];
    logic [3:0] m_rxa;
    logic [7:0] m_rxd;

    // Planned frame and expected per-cycle outputs
    logic [1:0] f_ctrl [$];
    logic [1:0] f_data [$];
    logic       e_ack [W], e_nak [W], e_rxv [W], e_rspv [W], e_busy [W];
    logic [1:0] e_rsp [W];
    logic       o_ack [W], o_nak [W], o_rxv [W], o_rspv [W], o_busy [W];
    logic [1:0] o_rsp [W];
    logic [3:0] o_rxa [W];
    logic [7:0] o_rxd [W];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        f_ctrl.delete();
        f_data.delete();
        for (int c = 0; c < W; c++) begin
            e_ack[c] = 0; e_nak[c] = 0; e_rxv[c] = 0; e_rspv[c] = 0; e_busy[c] = 0; e_rsp[c] = 2'b00;
        end
    endtask

    task automatic push_sym(input logic [1:0] c, input logic [1:0] d);
        f_ctrl.push_back(c);
        f_data.push_back(d);
    endtask

    task automatic push_byte(input logic [1:0] c, input logic [7:0] b);
        for (int i = 0; i < 4; i++) push_sym(c, b[7-2*i -: 2]);
    endtask

    task automatic set_busy(input int first, input int last);
        for (int c = first; c <= last; c++) e_busy[c] = 1;
    endtask

    // Write frame. clean=0 means a bad parity symbol, or without parity an illegal 5th DATA symbol.
    task automatic plan_write(input logic [7:0] hdr, input logic [7:0] data, input logic clean);
        int e;
        logic good_trailer;
        clear_plan();
        push_byte(CTRL_HEADER, hdr);
        push_byte(CTRL_DATA, data);
`ifdef FCP6_PARITY_EN
        push_sym(CTRL_DATA, {1'b0, clean ? ^data : ~^data});
        good_trailer = clean;
`else
        if (!clean) push_sym(CTRL_DATA, 2'b01);
        good_trailer = clean;
`endif
        push_sym(CTRL_END, 2'b00);
        e = f_ctrl.size() - 1;
        if (hdr[7:6] == CMD_RD && hdr[1:0] == SYNC_MARK) begin
            e_nak[5] = 1;
        end else begin
`ifndef FCP6_PARITY_EN
            if (!good_trailer) e_nak[9] = 1;
            else
`endif
            if (hdr[7:6] == CMD_WR && hdr[1:0] == SYNC_MARK && good_trailer) begin
                e_ack[e+1] = 1;
                e_rxv[e+1] = 1;
                m_rf[hdr[5:2]] = data;
                m_rxa = hdr[5:2];
                m_rxd = data;
            end else begin
                e_nak[e+1] = 1;
            end
        end
        set_busy(0, e + 1);
    endtask

    task automatic plan_read(input logic [7:0] hdr);
        logic [7:0] d;
        int ack_c;
        clear_plan();
        push_byte(CTRL_HEADER, hdr);
        push_sym(CTRL_END, 2'b00);
        if (hdr[7:6] == CMD_RD && hdr[1:0] == SYNC_MARK) begin
            d = m_rf[hdr[5:2]];
            for (int i = 0; i < 4; i++) begin
                e_rspv[5+i] = 1;
                e_rsp[5+i]  = d[7-2*i -: 2];
            end
            ack_c = 9;
`ifdef FCP6_PARITY_EN
            e_rspv[9] = 1;
            e_rsp[9]  = {1'b0, ^d};
            ack_c = 10;
`endif
            e_ack[ack_c] = 1;
            set_busy(0, ack_c);
        end else begin
            e_nak[5] = 1;
            set_busy(0, 5);
        end
    endtask

    // k header symbols, then m cycles of an out-of-place ctrl code, then IDLE.
    task automatic plan_framing(input logic [7:0] hdr, input int k, input logic [1:0] bad, input int m);
        clear_plan();
        for (int i = 0; i < k; i++) push_sym(CTRL_HEADER, hdr[7-2*i -: 2]);
        for (int i = 0; i < m; i++) push_sym(bad, 2'($urandom));
        e_nak[k+1] = 1;
        set_busy((k == 0) ? 1 : 0, k + m);
    endtask

    task automatic run_frame(input string name);
        for (int c = 0; c < W; c++) begin
            bus.bus_ctrl = (c < f_ctrl.size()) ? f_ctrl[c] : CTRL_IDLE;
            bus.bus_data = (c < f_data.size()) ? f_data[c] : 2'b00;
            @(negedge clk);
            o_ack[c] = bus.ack;   o_nak[c] = bus.nak;     o_rxv[c] = bus.rx_valid;
            o_rspv[c] = bus.rsp_valid; o_rsp[c] = bus.rsp_data; o_busy[c] = bus.busy;
            o_rxa[c] = bus.rx_addr; o_rxd[c] = bus.rx_data;
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < W; c++) begin
            check_eq($sformatf("%s ack@%0d", name, c), 32'(o_ack[c]), 32'(e_ack[c]));
            check_eq($sformatf("%s nak@%0d", name, c), 32'(o_nak[c]), 32'(e_nak[c]));
            check_eq($sformatf("%s rx_valid@%0d", name, c), 32'(o_rxv[c]), 32'(e_rxv[c]));
            check_eq($sformatf("%s rsp_valid@%0d", name, c), 32'(o_rspv[c]), 32'(e_rspv[c]));
            check_eq($sformatf("%s busy@%0d", name, c), 32'(o_busy[c]), 32'(e_busy[c]));
            if (e_rspv[c]) check_eq($sformatf("%s rsp_data@%0d", name, c), 32'(o_rsp[c]), 32'(e_rsp[c]));
            if (e_rxv[c]) begin
                check_eq($sformatf("%s rx_addr@%0d", name, c), 32'(o_rxa[c]), 32'(m_rxa));
                check_eq($sformatf("%s rx_data@%0d", name, c), 32'(o_rxd[c]), 32'(m_rxd));
            end
        end
        check_eq($sformatf("%s rx_addr end", name), 32'(bus.rx_addr), 32'(m_rxa));
        check_eq($sformatf("%s rx_data end", name), 32'(bus.rx_data), 32'(m_rxd));
    endtask

    function automatic logic [7:0] rand_hdr();
        logic [1:0] cmd, sync;
        logic [3:0] a;
        int r;
        r    = $urandom_range(0, 9);
        cmd  = (r < 4) ? CMD_WR : (r < 8) ? CMD_RD : 2'($urandom);
        sync = ($urandom_range(0, 7) == 0) ? 2'($urandom) : SYNC_MARK;
        a    = 4'($urandom_range(0, 5));
        return {cmd, a, sync};
    endfunction

    function automatic logic [18:0] all_outs();
        return {bus.ack, bus.nak, bus.rsp_valid, bus.rsp_data, bus.busy,
                bus.rx_valid, bus.rx_addr, bus.rx_data};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        m_rxa = 4'h0;
        m_rxd = 8'h00;

        // Reset: outputs low even with a header symbol on the link
        bus.bus_ctrl = CTRL_HEADER;
        bus.bus_data = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset outputs", 32'(all_outs()), 32'h0);
        bus.bus_ctrl = CTRL_IDLE;
        bus.bus_data = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;

        plan_write(8'h67, 8'hA5, 1'b1);  run_frame("t1 write");
        plan_read(8'hA7);                run_frame("t2 read");
        plan_write(8'h64, 8'h3C, 1'b1);  run_frame("t3 bad marker");
        plan_read(8'hA7);                run_frame("t3 readback");
        plan_framing(8'h67, 2, CTRL_DATA, 3); run_frame("t4 framing");
        plan_framing(8'h00, 0, CTRL_END, 2);  run_frame("t4 end while idle");
        plan_write(8'h5B, 8'h3C, 1'b1);  run_frame("t4 clean write");
        plan_read(8'h5B);                run_frame("t4 wr cmd then end");
        plan_write(8'hA7, 8'h11, 1'b1);  run_frame("t4 rd cmd with data");
        plan_write(8'h67, 8'h5A, 1'b0);  run_frame("t6 bad trailer");
        plan_read(8'hA7);                run_frame("t6 readback");
        plan_read(8'h9B);                run_frame("t4 readback addr6");

        // Reset in the middle of the data phase (third DATA symbol)
        clear_plan();
        push_byte(CTRL_HEADER, 8'h67);
        push_byte(CTRL_DATA, 8'h3C);
        for (int c = 0; c < 7; c++) begin
            bus.bus_ctrl = f_ctrl[c];
            bus.bus_data = f_data[c];
            if (c == 6) begin
                #1 rst_n = 1'b0;
                #1 check_eq("mid-frame reset outputs", 32'(all_outs()), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        bus.bus_ctrl = CTRL_IDLE;
        bus.bus_data = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        m_rxa = 4'h0;
        m_rxd = 8'h00;
        clear_plan();                    run_frame("t5 after reset");
        plan_read(8'hA7);                run_frame("t5 regfile reset");

        // Random frames
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0:       plan_write(rand_hdr(), 8'($urandom), $urandom_range(0, 3) != 0);
                1:       plan_read(rand_hdr());
                default: plan_framing(rand_hdr(), $urandom_range(0, 3),
                                      ($urandom_range(0, 1) != 0) ? CTRL_DATA : CTRL_END,
                                      $urandom_range(1, 3));
            endcase
            run_frame($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
